// File: rtl/sorted_display.sv
// Sorted-value display driver: captures four 4-bit sorted elements on the
// rising edge of sorting_done and multiplexes them onto a 4-digit,
// active-low, common-anode 7-segment display. Elements read ascending
// from left to right. The shared decimal point flashes after each capture.
//
// Scan sequence: ctr counts 0..REFRESH_DIV-1. Each wrap of ctr advances
// idx by one, modulo 4. Digit idx shows element idx on anode an[3-idx].
// The anodes stay blank while ctr is 0 or 1, so the old digit is off
// before the new digit is driven.
//
// The seg, dp and an outputs are registered. Each one lags the scan and
// capture state by one clock.
module sorted_display #(
    parameter int REFRESH_DIV  = 100000,
    parameter int FLASH_CYCLES = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] nums_in,
    input  logic        sorting_done,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        valid
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int FW = $clog2(FLASH_CYCLES + 1);

    localparam logic [CW-1:0] CTR_LAST   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CTR_ONE    = CW'(1);
    localparam logic [FW-1:0] FLASH_LOAD = FW'(FLASH_CYCLES);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_ERR   = 7'b0000110;

    // Segment encoding of one element, active-low {g,f,e,d,c,b,a}.
    // Values above 9 are shown as 'E'.
    function automatic logic [6:0] seg_encode(input logic [3:0] v);
        case (v)
            4'd0:    seg_encode = 7'b1000000;
            4'd1:    seg_encode = 7'b1111001;
            4'd2:    seg_encode = 7'b0100100;
            4'd3:    seg_encode = 7'b0110000;
            4'd4:    seg_encode = 7'b0011001;
            4'd5:    seg_encode = 7'b0010010;
            4'd6:    seg_encode = 7'b0000010;
            4'd7:    seg_encode = 7'b1111000;
            4'd8:    seg_encode = 7'b0000000;
            4'd9:    seg_encode = 7'b0010000;
            default: seg_encode = SEG_ERR;
        endcase
    endfunction

    logic          done_q;
    logic          capture;
    logic [15:0]   disp_q;
    logic          valid_q;
    logic [FW-1:0] flash_q;
    logic [CW-1:0] ctr_q;
    logic [1:0]    idx_q;

    logic [3:0]    digit;
    logic          blank;
    logic [6:0]    seg_nxt;
    logic [3:0]    an_nxt;
    logic          dp_nxt;

    // A capture happens only on the rising edge of the upstream done level.
    assign capture = sorting_done & ~done_q;

    // Delay sorting_done by one clock to detect its rising edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= sorting_done;
        end
    end

    // Latch the sorted values on a capture and (re)start the dp flash.
    // Otherwise the flash counter decrements and saturates at 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp_q  <= '0;
            valid_q <= 1'b0;
            flash_q <= '0;
        end else if (capture) begin
            disp_q  <= nums_in;
            valid_q <= 1'b1;
            flash_q <= FLASH_LOAD;
        end else if (flash_q != '0) begin
            flash_q <= flash_q - FW'(1);
        end
    end

    // Free-running scan counter. Each wrap advances the digit index.
    // Captures do not affect this counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctr_q <= '0;
            idx_q <= 2'd0;
        end else if (ctr_q == CTR_LAST) begin
            ctr_q <= '0;
            idx_q <= idx_q + 2'd1;
        end else begin
            ctr_q <= ctr_q + CW'(1);
        end
    end

    // Decode the current scan slot into the next seg/dp/an values.
    always_comb begin
        digit   = disp_q[{idx_q, 2'b00} +: 4];
        blank   = (ctr_q == '0) || (ctr_q == CTR_ONE);
        seg_nxt = valid_q ? seg_encode(digit) : SEG_DASH;
        an_nxt  = 4'b1111;
        if (!blank) begin
            an_nxt = ~(4'b1000 >> idx_q);
        end
        dp_nxt  = (flash_q == '0);
    end

    // Register the display outputs. Reset forces everything dark at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg <= SEG_BLANK;
            dp  <= 1'b1;
            an  <= 4'b1111;
        end else begin
            seg <= seg_nxt;
            dp  <= dp_nxt;
            an  <= an_nxt;
        end
    end

    assign valid = valid_q;

endmodule

// File: tb/tb_sorted_display.sv
// Directed bench for sorted_display with REFRESH_DIV=4 and FLASH_CYCLES=8.
// Inputs are driven and outputs sampled 1 ns after each rising clock edge.
// The variable cyc counts the rising edges since the last reset release.
// After edge n, the registered outputs reflect scan state n-1:
// ctr=(n-1)%4 and idx=((n-1)/4)%4.
module tb_sorted_display;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] nums_in = 16'h0000;
    logic        sorting_done = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        valid;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [6:0] tab [4];

    localparam logic [6:0] DASH = 7'b0111111;

    sorted_display #(
        .REFRESH_DIV (4),
        .FLASH_CYCLES(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .nums_in     (nums_in),
        .sorting_done(sorting_done),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .valid       (valid)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock and move to the sampling point.
    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Expected anodes after edge n.
    function automatic logic [3:0] exp_an_at(input int n);
        int c;
        int i;
        if (n < 1) return 4'b1111;
        c = (n - 1) % 4;
        i = ((n - 1) / 4) % 4;
        if (c < 2) return 4'b1111;
        return ~(4'b1000 >> i);
    endfunction

    // Expected element index on the display after edge n.
    function automatic int exp_idx_at(input int n);
        return ((n - 1) / 4) % 4;
    endfunction

    task automatic test_reset;
        rst = 1'b0;
        tick;
        tick;
        checks++;
        if (seg !== 7'b1111111) begin errors++; $display("FAIL reset_seg got %b expected 1111111", seg); end
        checks++;
        if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp got %b expected 1", dp); end
        checks++;
        if (an !== 4'b1111) begin errors++; $display("FAIL reset_an got %b expected 1111", an); end
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", valid); end
    endtask

    task automatic test_scan_dashes;
        rst = 1'b1;
        cyc = 0;
        for (int k = 1; k <= 16; k++) begin
            tick;
            checks++;
            if (an !== exp_an_at(cyc)) begin errors++; $display("FAIL scan_an cyc=%0d got %b expected %b", cyc, an, exp_an_at(cyc)); end
            if (an !== 4'b1111) begin
                checks++;
                if (seg !== DASH) begin errors++; $display("FAIL scan_dash cyc=%0d got %b expected %b", cyc, seg, DASH); end
            end
            checks++;
            if (dp !== 1'b1) begin errors++; $display("FAIL scan_dp cyc=%0d got %b expected 1", cyc, dp); end
            checks++;
            if (valid !== 1'b0) begin errors++; $display("FAIL scan_valid cyc=%0d got %b expected 0", cyc, valid); end
        end
    endtask

    task automatic test_capture_flash;
        tab[0] = 7'b1111001;
        tab[1] = 7'b0100100;
        tab[2] = 7'b0010010;
        tab[3] = 7'b0010000;
        nums_in = 16'h9521;
        sorting_done = 1'b1;
        tick;
        checks++;
        if (valid !== 1'b1) begin errors++; $display("FAIL cap_valid got %b expected 1", valid); end
        checks++;
        if (dp !== 1'b1) begin errors++; $display("FAIL cap_dp_edge got %b expected 1", dp); end
        // Hold sorting_done high and change the input. Neither may re-capture.
        nums_in = 16'h0000;
        for (int k = 1; k <= 20; k++) begin
            tick;
            checks++;
            if (dp !== ((k <= 8) ? 1'b0 : 1'b1)) begin errors++; $display("FAIL cap_dp k=%0d got %b expected %b", k, dp, (k <= 8) ? 1'b0 : 1'b1); end
            checks++;
            if (an !== exp_an_at(cyc)) begin errors++; $display("FAIL cap_an cyc=%0d got %b expected %b", cyc, an, exp_an_at(cyc)); end
            if (an !== 4'b1111) begin
                checks++;
                if (seg !== tab[exp_idx_at(cyc)]) begin errors++; $display("FAIL cap_seg an=%b got %b expected %b", an, seg, tab[exp_idx_at(cyc)]); end
            end
        end
        sorting_done = 1'b0;
        tick;
    endtask

    task automatic test_error_digit;
        tab[0] = 7'b1000000;
        tab[1] = 7'b0000110;
        tab[2] = 7'b1000000;
        tab[3] = 7'b1000000;
        nums_in = 16'h00C0;
        sorting_done = 1'b1;
        tick;
        sorting_done = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            tick;
            if (an !== 4'b1111) begin
                checks++;
                if (seg !== tab[exp_idx_at(cyc)]) begin errors++; $display("FAIL err_seg an=%b got %b expected %b", an, seg, tab[exp_idx_at(cyc)]); end
            end
        end
    endtask

    task automatic test_recapture;
        tab[0] = 7'b0010010;
        tab[1] = 7'b0000010;
        tab[2] = 7'b1111000;
        tab[3] = 7'b0000000;
        nums_in = 16'h4321;
        sorting_done = 1'b1;
        tick;
        sorting_done = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick;
            checks++;
            if (dp !== 1'b0) begin errors++; $display("FAIL recap_dp_first k=%0d got %b expected 0", k, dp); end
        end
        nums_in = 16'h8765;
        sorting_done = 1'b1;
        tick;
        checks++;
        if (dp !== 1'b0) begin errors++; $display("FAIL recap_dp_edge got %b expected 0", dp); end
        sorting_done = 1'b0;
        nums_in = 16'hFFFF;
        for (int k = 1; k <= 17; k++) begin
            tick;
            checks++;
            if (dp !== ((k <= 8) ? 1'b0 : 1'b1)) begin errors++; $display("FAIL recap_dp k=%0d got %b expected %b", k, dp, (k <= 8) ? 1'b0 : 1'b1); end
            if (an !== 4'b1111) begin
                checks++;
                if (seg !== tab[exp_idx_at(cyc)]) begin errors++; $display("FAIL recap_seg an=%b got %b expected %b", an, seg, tab[exp_idx_at(cyc)]); end
            end
        end
    endtask

    task automatic test_reset_mid_flash;
        sorting_done = 1'b0;
        // Step until the state before the next edge is ctr=3, idx=1.
        for (int g = 0; g < 20; g++) begin
            if ((cyc % 4 == 3) && ((cyc / 4) % 4 == 1)) break;
            tick;
        end
        nums_in = 16'h1111;
        sorting_done = 1'b1;
        tick;
        sorting_done = 1'b0;
        tick;
        tick;
        tick;
        checks++;
        if (an !== 4'b1101) begin errors++; $display("FAIL rmid_an_pre got %b expected 1101", an); end
        checks++;
        if (dp !== 1'b0) begin errors++; $display("FAIL rmid_dp_pre got %b expected 0", dp); end
        rst = 1'b0;
        #1;
        checks++;
        if (seg !== 7'b1111111) begin errors++; $display("FAIL rmid_seg got %b expected 1111111", seg); end
        checks++;
        if (dp !== 1'b1) begin errors++; $display("FAIL rmid_dp got %b expected 1", dp); end
        checks++;
        if (an !== 4'b1111) begin errors++; $display("FAIL rmid_an got %b expected 1111", an); end
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b expected 0", valid); end
        tick;
        tick;
        rst = 1'b1;
        cyc = 0;
        for (int k = 1; k <= 4; k++) begin
            tick;
            checks++;
            if (an !== exp_an_at(cyc)) begin errors++; $display("FAIL rmid_scan_an cyc=%0d got %b expected %b", cyc, an, exp_an_at(cyc)); end
            if (an !== 4'b1111) begin
                checks++;
                if (seg !== DASH) begin errors++; $display("FAIL rmid_scan_seg cyc=%0d got %b expected %b", cyc, seg, DASH); end
            end
            checks++;
            if (dp !== 1'b1) begin errors++; $display("FAIL rmid_scan_dp cyc=%0d got %b expected 1", cyc, dp); end
        end
    endtask

    task automatic test_capture_at_release;
        rst = 1'b0;
        tick;
        nums_in = 16'h0987;
        sorting_done = 1'b1;
        tick;
        rst = 1'b1;
        cyc = 0;
        tick;
        checks++;
        if (valid !== 1'b1) begin errors++; $display("FAIL rel_valid got %b expected 1", valid); end
        sorting_done = 1'b0;
        tab[0] = 7'b1111000;
        tab[1] = 7'b0000000;
        tab[2] = 7'b0010000;
        tab[3] = 7'b1000000;
        tick;
        checks++;
        if (dp !== 1'b0) begin errors++; $display("FAIL rel_dp got %b expected 0", dp); end
        for (int k = 1; k <= 16; k++) begin
            tick;
            if (an !== 4'b1111) begin
                checks++;
                if (seg !== tab[exp_idx_at(cyc)]) begin errors++; $display("FAIL rel_seg an=%b got %b expected %b", an, seg, tab[exp_idx_at(cyc)]); end
            end
        end
    endtask

    initial begin
        test_reset;
        test_scan_dashes;
        test_capture_flash;
        test_error_digit;
        test_recapture;
        test_reset_mid_flash;
        test_capture_at_release;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
